// File: rtl/spm_driver.sv
// spm_driver: sequencing front/back end for one serial-parallel multiplier (spm).
// Holds the parallel operand on spm_x, shifts the serial operand LSB-first into
// spm_y, clears the multiplier before each product, and collects the serial
// product into a parallel 2*SIZE-bit result behind a valid/ready handshake.
// Optional feature: define SPM_DRV_ZERO_BYPASS_EN so that a zero operand skips
// straight to DONE with a zero product.
module spm_driver #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned P_DELAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_x,
    input  logic [SIZE-1:0]   in_y,
    output logic [SIZE-1:0]   spm_x,
    output logic              spm_y,
    output logic              spm_rst,
    input  logic              spm_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] out_prod
);

    localparam int unsigned CW = $clog2(2 * SIZE + P_DELAY + 1);
    localparam logic [CW-1:0] LastCnt = CW'(2 * SIZE + P_DELAY - 1);
    localparam logic [CW-1:0] FirstCapture = CW'(P_DELAY);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [SIZE-1:0]   x_q;
    logic [SIZE-1:0]   y_q;
    logic [CW-1:0]     cnt_q;
    logic [2*SIZE-1:0] prod_q;
    logic              accept;

    assign accept = (state_q == StIdle) && in_valid;

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
`ifdef SPM_DRV_ZERO_BYPASS_EN
                    // A zero operand gives a zero product; no need to run the spm.
                    state_d = ((in_x == '0) || (in_y == '0)) ? StDone : StClear;
`else
                    state_d = StClear;
`endif
                end
            end
            StClear: state_d = StShift;
            StShift: begin
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, operand registers, bit counter and product deserialiser.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q    <= in_x;
                y_q    <= in_y;
                cnt_q  <= '0;
                prod_q <= '0;
            end
            if (state_q == StShift) begin
                // Zero fill: once the operand is exhausted spm sees 0 for the upper half.
                y_q   <= y_q >> 1;
                cnt_q <= cnt_q + CW'(1);
                // The first P_DELAY samples precede product bit 0 on spm_p.
                if (cnt_q >= FirstCapture) begin
                    prod_q <= {spm_p, prod_q[2*SIZE-1:1]};
                end
            end
        end
    end

    assign spm_x    = x_q;
    assign spm_y    = (state_q == StShift) && y_q[0];
    assign spm_rst  = rst || (state_q == StClear);
    assign out_prod = prod_q;

endmodule

// File: tb/tb_spm_driver.sv
// Self-checking bench for spm_driver with a behavioural spm model attached.
// Expected products are queued at accept time and compared on output handshake.
module tb_spm_driver;

    localparam int unsigned SIZE = 32;
    localparam int unsigned PD   = 1;
    localparam int LAT = 2 + 2 * SIZE + PD;
`ifdef SPM_DRV_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = LAT;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SIZE-1:0]   in_x = '0;
    logic [SIZE-1:0]   in_y = '0;
    logic [SIZE-1:0]   spm_x;
    logic              spm_y;
    logic              spm_rst;
    logic              spm_p;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2*SIZE-1:0] out_prod;

    always #5 clk = ~clk;

    spm_driver #(.SIZE(SIZE), .P_DELAY(PD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_rst   (spm_rst),
        .spm_p     (spm_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );

    // Behavioural serial-parallel multiplier: bit k of the running sum is final
    // once y bit k has been added, and it appears on p one cycle later.
    logic [127:0] acc;
    logic [6:0]   kk;
    logic         p_q;
    logic [127:0] acc_nxt;
    assign acc_nxt = acc + (spm_y ? (128'(spm_x) << kk) : 128'd0);
    assign spm_p   = p_q;

    always @(posedge clk) begin
        if (spm_rst) begin
            acc <= '0;
            kk  <= '0;
            p_q <= 1'b0;
        end else begin
            acc <= acc_nxt;
            kk  <= kk + 7'd1;
            p_q <= acc_nxt[kk];
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [63:0] sb_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare the product on each output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got product %0h with no pending operation", out_prod);
            end else begin
                sb_exp = sb.pop_front();
                if (out_prod !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_product: got %0h expected %0h", out_prod, sb_exp);
                end
            end
        end
    end

    // Issue one operand pair and follow it until out_valid; checks latency,
    // spm_rst pulse, serial y stream, spm_x holding and in_ready while busy.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp,
                          input int lat, input string name);
        int          seen_at;
        int          rst_cnt;
        int          rst_first;
        int          busy_rdy;
        int          x_bad;
        logic [64:0] tr;
        seen_at = -1;
        rst_cnt = 0;
        rst_first = -1;
        busy_rdy = 0;
        x_bad = 0;
        tr = '0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        @(negedge clk);
        check({name, "_in_ready"}, 128'(in_ready), 128'd1);
        sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x = $urandom;
        in_y = $urandom;
        for (int i = 1; i <= 300 && seen_at < 0; i++) begin
            @(negedge clk);
            if (spm_rst) begin
                rst_cnt++;
                if (rst_first < 0) rst_first = i;
            end
            if (spm_x !== x) x_bad++;
            if (in_ready) busy_rdy++;
            if (out_valid) seen_at = i;
            else if (i >= 2 && (i - 2) < int'(2 * SIZE + PD)) tr[i-2] = spm_y;
        end
        check({name, "_latency"}, 128'(seen_at), 128'(lat));
        check({name, "_spm_x_hold"}, 128'(x_bad), 128'd0);
        check({name, "_busy_in_ready"}, 128'(busy_rdy), 128'd0);
        if (lat == 1) begin
            check({name, "_no_spm_rst"}, 128'(rst_cnt), 128'd0);
        end else begin
            check({name, "_spm_rst_count"}, 128'(rst_cnt), 128'd1);
            check({name, "_spm_rst_cycle"}, 128'(rst_first), 128'd1);
            check({name, "_y_stream"}, 128'(tr), 128'({33'b0, y}));
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] held;
    int          bp_bad;
    logic [31:0] rx;
    logic [31:0] ry;

    initial begin
        vecs[0] = '{x: 32'd3,          y: 32'd5,          p: 64'd15};
        vecs[1] = '{x: 32'hFFFF_FFFF,  y: 32'hFFFF_FFFF,  p: 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{x: 32'd1,          y: 32'd1,          p: 64'd1};
        vecs[3] = '{x: 32'h0000_FFFF,  y: 32'h0001_0000,  p: 64'h0000_0000_FFFF_0000};
        vecs[4] = '{x: 32'h0001_0000,  y: 32'h0001_0000,  p: 64'h0000_0001_0000_0000};
        vecs[5] = '{x: 32'hFFFF_FFFF,  y: 32'd1,          p: 64'h0000_0000_FFFF_FFFF};
        vecs[6] = '{x: 32'd1,          y: 32'hFFFF_FFFF,  p: 64'h0000_0000_FFFF_FFFF};
        vecs[7] = '{x: 32'h8000_0000,  y: 32'h8000_0000,  p: 64'h4000_0000_0000_0000};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_prod", 128'(out_prod), 128'd0);
        check("rst_spm_x", 128'(spm_x), 128'd0);
        check("rst_spm_y", 128'(spm_y), 128'd0);
        check("rst_spm_rst", 128'(spm_rst), 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_spm_rst", 128'(spm_rst), 128'd0);

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].x, vecs[v].y, vecs[v].p, LAT, $sformatf("vec%0d", v));
        end

        // Back-to-back with a stale result in the multiplier.
        run_op(32'd7, 32'd9, 64'd63, LAT, "b2b_a");
        run_op(32'h8000_0000, 32'd2, 64'h1_0000_0000, LAT, "b2b_b");

        // Random operands against a 64-bit reference multiply.
        for (int r = 0; r < 3; r++) begin
            rx = $urandom;
            ry = $urandom;
            run_op(rx, ry, 64'(rx) * 64'(ry), LAT, $sformatf("rand%0d", r));
        end

        // Backpressure: hold out_ready low for 20 cycles in DONE.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        run_op(32'd1000, 32'd3000, 64'd3000000, LAT, "bp");
        held = out_prod;
        bp_bad = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (out_prod !== 64'd3000000 || in_ready || !out_valid) bp_bad++;
        end
        check("bp_stall_stable", 128'(bp_bad), 128'd0);
        check("bp_held_value", 128'(held), 128'd3000000);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_idle_ready", 128'(in_ready), 128'd1);
        check("bp_release_idle_valid", 128'(out_valid), 128'd0);

        // Reset in the middle of SHIFT (count 10).
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x = 32'd100;
        in_y = 32'd200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_spm_rst", 128'(spm_rst), 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        run_op(32'd6, 32'd7, 64'd42, LAT, "after_rst");

        // Zero operand.
        run_op(32'd0, 32'h1234, 64'd0, ZLAT, "zero");
        run_op(32'd11, 32'd13, 64'd143, LAT, "after_zero");

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
